// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store
// path and main memory. Line refills use a req/ack handshake while the CPU is stalled.
module data_cache #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    logic [1:0]            state;
    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][WORDS_PER_LINE];
    logic [OFF_W-1:0]      word_cnt;
    logic [OFF_W-1:0]      next_cnt;

    logic [OFF_W-1:0] cpu_word;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             hit;
    logic             load_hit;
    logic             load_miss;
    logic             store_req;
    logic             refill_ack;
    logic             write_done;
    logic             flush_ok;
    logic             unused_bits;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign cpu_word    = cpu_addr[2 +: OFF_W];
    assign cpu_idx     = cpu_addr[2 + OFF_W +: IDX_W];
    assign cpu_tag     = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_bits = &{1'b0, cpu_addr[1:0]};
    assign next_cnt    = word_cnt + {{(OFF_W-1){1'b0}}, 1'b1};

    assign hit        = valid[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
    assign load_hit   = (state == S_IDLE) & cpu_req & ~cpu_we & hit;
    assign load_miss  = (state == S_IDLE) & cpu_req & ~cpu_we & ~hit;
    assign store_req  = (state == S_IDLE) & cpu_req & cpu_we;
    assign refill_ack = (state == S_REFILL) & mem_req & mem_ack;
    assign write_done = (state == S_WRITE) & mem_req & mem_ack;

    // A store releases the CPU in its ack cycle so the held store is not replayed.
    assign cpu_stall = ~rst & cpu_req & ~load_hit & ~write_done;
    assign cpu_rdata = (~rst & load_hit) ? data_mem[cpu_idx][cpu_word] : '0;
    assign flush_ok  = (state == S_IDLE) & flush & ~cpu_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            valid      <= '0;
            word_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_ok)
                        valid <= '0;
                    if (load_hit)
                        hit_count <= sat_inc(hit_count);
                    if (load_miss) begin
                        state      <= S_REFILL;
                        word_cnt   <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {cpu_tag, cpu_idx, {OFF_W{1'b0}}, 2'b00};
                        miss_count <= sat_inc(miss_count);
                    end else if (store_req) begin
                        state     <= S_WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                    end
                end
                S_REFILL: begin
                    if (refill_ack) begin
                        if (word_cnt == LAST_WORD) begin
                            valid[cpu_idx] <= 1'b1;
                            state          <= S_IDLE;
                            mem_req        <= 1'b0;
                            word_cnt       <= '0;
                        end else begin
                            word_cnt <= next_cnt;
                            mem_addr <= {cpu_tag, cpu_idx, next_cnt, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    if (write_done) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line storage: never reset, only made visible through valid.
    always_ff @(posedge clk) begin
        if (refill_ack)
            data_mem[cpu_idx][word_cnt] <= mem_rdata;
        if (refill_ack && word_cnt == LAST_WORD)
            tag_mem[cpu_idx] <= cpu_tag;
        if (write_done && hit)
            data_mem[cpu_idx][cpu_word] <= cpu_wdata;
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a memory responder, a transaction-level cache model
// and a per-cycle load-data compare process.
module tb_data_cache;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 16;
    localparam int WPL = 4;
    localparam int CW  = 32;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          flush;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    data_cache #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETS(NS), .WORDS_PER_LINE(WPL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Backing memory: word at byte address A initially holds 0xC0DE0000 + A.
    logic [31:0] tb_mem [1024];
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    logic [31:0] rd_log [$];
    wr_t         wr_log [$];
    int          ack_total = 0;

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'hC0DE_0000 + 32'(i * 4);
    end

    // Acknowledges every other cycle while mem_req is up.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !rst) begin
                mem_ack = 1'b1;
                ack_total++;
                if (mem_we) begin
                    tb_mem[mem_addr[11:2]] = mem_wdata;
                    wr_log.push_back('{a: mem_addr, d: mem_wdata});
                end else begin
                    mem_rdata = tb_mem[mem_addr[11:2]];
                    rd_log.push_back(mem_addr);
                end
            end
        end
    end

    // Cache model: which lines are resident, plus expected counters.
    logic        mdl_valid [NS];
    logic [23:0] mdl_tag   [NS];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    function automatic bit mdl_hit(input logic [31:0] a);
        return mdl_valid[a[7:4]] && (mdl_tag[a[7:4]] == a[31:8]);
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < NS; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic mdl_reset();
        mdl_clear();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Write-through: every completed load must return the current memory word.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && cpu_req && !cpu_we && !cpu_stall) begin
                chk("load_rdata", cpu_rdata, tb_mem[cpu_addr[11:2]]);
                chk("hit_mem_req", 32'(mem_req), 32'd0);
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic fl, output logic [31:0] rd);
        bit h;
        int cyc;
        h = mdl_hit(a);
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        flush    = fl;
        #1;
        cyc = 0;
        while (cpu_stall && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("load_timeout", 32'(cpu_stall), 32'd0);
        chk("load_latency", 32'(cyc), h ? 32'd0 : 32'(2 * WPL));
        rd = cpu_rdata;
        if (!h) begin
            exp_misses++;
            mdl_valid[a[7:4]] = 1'b1;
            mdl_tag[a[7:4]]   = a[31:8];
        end
        exp_hits++;
        if (fl) mdl_clear();
        @(negedge clk);
        cpu_req = 1'b0;
        flush   = 1'b0;
        #1;
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
        chk("load_mem_reads", 32'(rd_log.size()), h ? 32'd0 : 32'(WPL));
        chk("load_mem_writes", 32'(wr_log.size()), 32'd0);
        if (!h && rd_log.size() == WPL)
            for (int k = 0; k < WPL; k++)
                chk("refill_addr", rd_log[k], {a[31:4], 4'b0} + 32'(4 * k));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int cyc;
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        cyc = 0;
        while (cpu_stall && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("store_timeout", 32'(cpu_stall), 32'd0);
        chk("store_latency", 32'(cyc), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        #1;
        chk("store_mem_writes", 32'(wr_log.size()), 32'd1);
        chk("store_mem_reads", 32'(rd_log.size()), 32'd0);
        if (wr_log.size() == 1) begin
            chk("store_addr", wr_log[0].a, {a[31:2], 2'b00});
            chk("store_data", wr_log[0].d, d);
        end
        chk("store_hit_count", hit_count, exp_hits);
        chk("store_miss_count", miss_count, exp_misses);
    endtask

    task automatic do_flush();
        @(negedge clk);
        cpu_req = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        mdl_clear();
    endtask

    logic [31:0] rd;
    int          start_acks;
    int          cyc;

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h40;
        cpu_wdata = '0;
        flush     = 1'b0;
        mdl_reset();

        // Reset state, with a load presented while reset is held
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        cpu_req = 1'b0;
        rst     = 1'b0;

        // Cold miss on 0x40 then a hit in the same line
        do_load(32'h40, 1'b0, rd);
        chk("t1_miss_lit", miss_count, 32'd1);
        chk("t1_rdata_lit", rd, 32'hC0DE_0040);
        do_load(32'h48, 1'b0, rd);
        chk("t2_rdata_lit", rd, 32'hC0DE_0048);
        chk("t2_hits_lit", hit_count, 32'd2);

        // Store hit updates both memory and the line
        do_store(32'h44, 32'hDEAD_BEEF);
        do_load(32'h44, 1'b0, rd);
        chk("t3_rdata_lit", rd, 32'hDEAD_BEEF);

        // Store miss does not allocate
        do_store(32'h400, 32'h1234_5678);
        do_load(32'h400, 1'b0, rd);
        chk("t4_rdata_lit", rd, 32'h1234_5678);
        chk("t4_miss_lit", miss_count, 32'd2);

        // Conflict on index 4
        do_load(32'h40, 1'b0, rd);
        do_load(32'h140, 1'b0, rd);
        chk("t5_rdata_lit", rd, 32'hC0DE_0140);
        do_load(32'h40, 1'b0, rd);
        chk("t5_miss_lit", miss_count, 32'd4);

        // Flush with a load hit in the same cycle: load completes, then invalidates
        do_load(32'h40, 1'b1, rd);
        do_load(32'h40, 1'b0, rd);
        chk("t6_miss_lit", miss_count, 32'd5);

        // Flush alone invalidates every resident line
        do_load(32'h400, 1'b0, rd);
        do_load(32'h48, 1'b0, rd);
        do_flush();
        do_load(32'h48, 1'b0, rd);
        do_load(32'h400, 1'b0, rd);

        // Reset after the second refill ack aborts the refill
        do_flush();
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h40;
        start_acks = ack_total;
        cyc        = 0;
        #1;
        while ((ack_total - start_acks) < 2 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("t8_two_acks", 32'(ack_total - start_acks), 32'd2);
        @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        chk("t8_mem_req", 32'(mem_req), 32'd0);
        chk("t8_miss_cnt", miss_count, 32'd0);
        rst = 1'b0;
        mdl_reset();
        do_load(32'h40, 1'b0, rd);
        chk("t8_miss_lit", miss_count, 32'd1);
        chk("t8_rdata_lit", rd, 32'hC0DE_0040);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
